// File: rtl/sdram_arb_pkg.sv
// Shared state encoding, default widths and sizing helper for the SDRAM port arbiter.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    localparam int DEF_ADDR_W = 24;
    localparam int DEF_DATA_W = 32;

    // Width of a requester index; never below one bit.
    function automatic int gid_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/sdram_rr_picker.sv
// Rotating-priority encoder: first asserted request at or above rr_ptr_i, wrapping.
module sdram_rr_picker
    import sdram_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [gid_width(NUM_REQ)-1:0] rr_ptr_i,
    output logic                          any_o,
    output logic [gid_width(NUM_REQ)-1:0] winner_o
);

    localparam int GW = gid_width(NUM_REQ);

    // Walk offsets from farthest to nearest so the nearest hit overwrites the rest.
    always_comb begin
        logic [GW-1:0] idx;
        any_o    = 1'b0;
        winner_o = '0;
        idx      = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx      = GW'((int'(rr_ptr_i) + i) % NUM_REQ);
            any_o    = any_o | req_i[idx];
            winner_o = req_i[idx] ? idx : winner_o;
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller command/response port between
// NUM_REQ requesters, one outstanding transaction, with a response timeout.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 1024
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]     req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_W-1:0]             rsp_rdata,
    output logic                          rsp_err,
    output logic [gid_width(NUM_REQ)-1:0] grant_id,
    output logic                          busy,
    output logic                          err_stray,
    output logic                          mem_cmd_valid,
    input  logic                          mem_cmd_ready,
    output logic                          mem_cmd_we,
    output logic [ADDR_W-1:0]             mem_cmd_addr,
    output logic [DATA_W-1:0]             mem_cmd_wdata,
    input  logic                          mem_rsp_valid,
    input  logic [DATA_W-1:0]             mem_rsp_rdata
);

    localparam int GW = gid_width(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    arb_state_t          state_q, state_d;
    logic [GW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]       grant_q, grant_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;
    logic                busy_q;
    logic                err_stray_q, err_stray_d;
    logic                cmd_valid_q;
    logic                cmd_we_q, cmd_we_d;
    logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0]   cmd_wdata_q, cmd_wdata_d;

    logic                pick_any_s;
    logic [GW-1:0]       pick_id_s;
    logic                sel_we_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [DATA_W-1:0]   sel_wdata_s;

    sdram_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req_i    (req_valid),
        .rr_ptr_i (rr_ptr_q),
        .any_o    (pick_any_s),
        .winner_o (pick_id_s)
    );

    // Mux the winning requester's command fields out of the packed buses.
    always_comb begin
        sel_we_s    = 1'b0;
        sel_addr_s  = '0;
        sel_wdata_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_we_s    = (pick_id_s == GW'(i)) ? req_we[i] : sel_we_s;
            sel_addr_s  = (pick_id_s == GW'(i)) ? req_addr[i*ADDR_W +: ADDR_W] : sel_addr_s;
            sel_wdata_s = (pick_id_s == GW'(i)) ? req_wdata[i*DATA_W +: DATA_W] : sel_wdata_s;
        end
    end

    // Next-state and next-value logic for the transaction sequencer.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        cnt_d       = cnt_q;
        req_ready_d = '0;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        cmd_we_d    = cmd_we_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        err_stray_d = err_stray_q | (mem_rsp_valid & (state_q != ST_WAIT));
        case (state_q)
            ST_IDLE: begin
                if (pick_any_s) begin
                    state_d     = ST_ISSUE;
                    grant_d     = pick_id_s;
                    req_ready_d = ONE_HOT0 << pick_id_s;
                    cmd_we_d    = sel_we_s;
                    cmd_addr_d  = sel_addr_s;
                    cmd_wdata_d = sel_wdata_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (mem_cmd_ready) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                // A response arriving on the timeout cycle still counts as success.
                if (mem_rsp_valid) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = ONE_HOT0 << grant_q;
                    rsp_rdata_d = cmd_we_q ? '0 : mem_rsp_rdata;
                    rsp_err_d   = 1'b0;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = ONE_HOT0 << grant_q;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_RESP: begin
                state_d  = ST_IDLE;
                rr_ptr_d = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + GW'(1);
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any in-flight command silently.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            cnt_q       <= '0;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            err_stray_q <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= (state_d != ST_IDLE);
            err_stray_q <= err_stray_d;
            cmd_valid_q <= (state_d == ST_ISSUE);
            cmd_we_q    <= cmd_we_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
        end
    end

    assign req_ready     = req_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_err       = rsp_err_q;
    assign grant_id      = grant_q;
    assign busy          = busy_q;
    assign err_stray     = err_stray_q;
    assign mem_cmd_valid = cmd_valid_q;
    assign mem_cmd_we    = cmd_we_q;
    assign mem_cmd_addr  = cmd_addr_q;
    assign mem_cmd_wdata = cmd_wdata_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: vector table of single transactions plus
// hand-written round-robin, stray-response and mid-transaction reset sequences.
module tb_sdram_port_arbiter;

    localparam int NR = 4;
    localparam int AW = 24;
    localparam int DW = 32;
    localparam int TO = 16;

    logic            clk;
    logic            reset_n;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_we;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic [NR-1:0]   req_ready;
    logic [NR-1:0]   rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err;
    logic [1:0]      grant_id;
    logic            busy;
    logic            err_stray;
    logic            mem_cmd_valid;
    logic            mem_cmd_ready;
    logic            mem_cmd_we;
    logic [AW-1:0]   mem_cmd_addr;
    logic [DW-1:0]   mem_cmd_wdata;
    logic            mem_rsp_valid;
    logic [DW-1:0]   mem_rsp_rdata;

    int total;
    int bad;

    sdram_port_arbiter #(
        .NUM_REQ (NR),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .grant_id      (grant_id),
        .busy          (busy),
        .err_stray     (err_stray),
        .mem_cmd_valid (mem_cmd_valid),
        .mem_cmd_ready (mem_cmd_ready),
        .mem_cmd_we    (mem_cmd_we),
        .mem_cmd_addr  (mem_cmd_addr),
        .mem_cmd_wdata (mem_cmd_wdata),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_rdata (mem_rsp_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic        we;
        logic [23:0] addr;
        logic [31:0] wdata;
        int          rdy_dly;   // cycles mem_cmd_ready stays low in ISSUE
        int          rsp_dly;   // response sampled this many edges after handshake; 0 = never
        logic [31:0] mrdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_cyc;   // edges from handshake to rsp_valid
        int          exp_lat;   // edges from request sample to rsp_valid
    } vec_t;

    vec_t vecs[6];

    function automatic vec_t mk(input int id, input logic we, input logic [23:0] addr,
                                input logic [31:0] wdata, input int rdy, input int rsp,
                                input logic [31:0] mrd, input logic [31:0] erd,
                                input logic eerr, input int ecyc, input int elat);
        vec_t v;
        v.id = id; v.we = we; v.addr = addr; v.wdata = wdata;
        v.rdy_dly = rdy; v.rsp_dly = rsp; v.mrdata = mrd;
        v.exp_rdata = erd; v.exp_err = eerr; v.exp_cyc = ecyc; v.exp_lat = elat;
        return v;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " req_ready"}, 64'(req_ready), 64'd0);
        check({tag, " rsp_valid"}, 64'(rsp_valid), 64'd0);
        check({tag, " rsp_rdata"}, 64'(rsp_rdata), 64'd0);
        check({tag, " rsp_err"}, 64'(rsp_err), 64'd0);
        check({tag, " grant_id"}, 64'(grant_id), 64'd0);
        check({tag, " busy"}, 64'(busy), 64'd0);
        check({tag, " err_stray"}, 64'(err_stray), 64'd0);
        check({tag, " cmd_valid"}, 64'(mem_cmd_valid), 64'd0);
        check({tag, " cmd_we"}, 64'(mem_cmd_we), 64'd0);
        check({tag, " cmd_addr"}, 64'(mem_cmd_addr), 64'd0);
        check({tag, " cmd_wdata"}, 64'(mem_cmd_wdata), 64'd0);
    endtask

    // Runs one complete transaction; entered and left at a negedge with the DUT idle.
    task automatic run_vec(input vec_t v);
        logic [3:0] oh;
        bit got;
        oh = 4'b0001 << v.id;
        req_valid[v.id] = 1'b1;
        req_we[v.id] = v.we;
        req_addr[v.id*AW +: AW] = v.addr;
        req_wdata[v.id*DW +: DW] = v.wdata;
        mem_cmd_ready = 1'b0;
        mem_rsp_rdata = v.mrdata;
        @(negedge clk);
        check("req_ready", 64'(req_ready), 64'(oh));
        check("cmd_valid", 64'(mem_cmd_valid), 64'd1);
        check("cmd_addr", 64'(mem_cmd_addr), 64'(v.addr));
        check("cmd_we", 64'(mem_cmd_we), 64'(v.we));
        if (v.we) check("cmd_wdata", 64'(mem_cmd_wdata), 64'(v.wdata));
        check("grant_id", 64'(grant_id), 64'(v.id));
        check("busy_issue", 64'(busy), 64'd1);
        req_valid[v.id] = 1'b0;
        req_addr[v.id*AW +: AW] = 24'hFFFFFF;
        mem_cmd_ready = (v.rdy_dly == 0);
        for (int k = 1; k <= v.rdy_dly; k++) begin
            @(negedge clk);
            check("bp_cmd_valid", 64'(mem_cmd_valid), 64'd1);
            check("bp_cmd_addr", 64'(mem_cmd_addr), 64'(v.addr));
            if (k == v.rdy_dly) mem_cmd_ready = 1'b1;
        end
        @(negedge clk);
        check("cmd_valid_drop", 64'(mem_cmd_valid), 64'd0);
        mem_cmd_ready = 1'b0;
        got = 1'b0;
        for (int c = 1; c <= 40 && !got; c++) begin
            mem_rsp_valid = (c == v.rsp_dly);
            @(negedge clk);
            mem_rsp_valid = 1'b0;
            if (rsp_valid != 4'b0000) begin
                got = 1'b1;
                check("rsp_cycle", 64'(c), 64'(v.exp_cyc));
                check("rsp_latency", 64'(1 + v.rdy_dly + c), 64'(v.exp_lat));
                check("rsp_valid", 64'(rsp_valid), 64'(oh));
                check("rsp_rdata", 64'(rsp_rdata), 64'(v.exp_rdata));
                check("rsp_err", 64'(rsp_err), 64'(v.exp_err));
            end
        end
        if (!got) check("rsp_arrived", 64'd0, 64'd1);
        @(negedge clk);
        check("rsp_pulse_end", 64'(rsp_valid), 64'd0);
        check("busy_idle", 64'(busy), 64'd0);
    endtask

    int exp_rr[10] = '{0, 1, 3, 0, 1, 3, 0, 1, 2, 3};

    initial begin
        int n;
        int last_cyc;
        bit prev_cv;
        total = 0;
        bad = 0;
        reset_n = 1'b0;
        req_valid = '0;
        req_we = '0;
        req_addr = '0;
        req_wdata = '0;
        mem_cmd_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = '0;

        vecs[0] = mk(2, 1'b0, 24'h000123, 32'h0, 0, 2, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 2, 3);
        vecs[1] = mk(1, 1'b1, 24'h00ABCD, 32'h000000FF, 0, 1, 32'h12345678, 32'h0, 1'b0, 1, 2);
        vecs[2] = mk(0, 1'b0, 24'h5A5A5A, 32'h0, 7, 3, 32'hA5A50001, 32'hA5A50001, 1'b0, 3, 11);
        vecs[3] = mk(3, 1'b0, 24'h000010, 32'h0, 0, 16, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 16, 17);
        vecs[4] = mk(0, 1'b0, 24'hFFFFFE, 32'h0, 0, 1, 32'h0BADF00D, 32'h0BADF00D, 1'b0, 1, 2);
        vecs[5] = mk(3, 1'b0, 24'h123456, 32'h0, 0, 0, 32'hFFFFFFFF, 32'h0, 1'b1, 16, 17);

        repeat (2) @(negedge clk);
        check_all_zero("in_reset");
        reset_n = 1'b1;
        @(negedge clk);
        check_all_zero("after_reset");

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Late response after the timeout: flagged, never forwarded.
        check("stray_before", 64'(err_stray), 64'd0);
        mem_rsp_valid = 1'b1;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        check("stray_set", 64'(err_stray), 64'd1);
        check("stray_no_rsp", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        check("stray_sticky", 64'(err_stray), 64'd1);
        check("stray_no_rsp2", 64'(rsp_valid), 64'd0);

        // Round robin with requesters 0,1,3 held from reset; 2 joins mid-run.
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < NR; i++) begin
            req_we[i] = 1'b0;
            req_addr[i*AW +: AW] = 24'(i);
        end
        req_valid = 4'b1011;
        mem_cmd_ready = 1'b1;
        n = 0;
        last_cyc = 0;
        prev_cv = 1'b0;
        for (int cyc = 0; cyc < 200 && !(n >= 10 && busy == 1'b0); cyc++) begin
            @(negedge clk);
            mem_rsp_valid = prev_cv;
            prev_cv = mem_cmd_valid;
            if (req_ready != 4'b0000 && n < 10) begin
                check("rr_grant", 64'(req_ready), 64'(4'b0001 << exp_rr[n]));
                if (n > 0) check("rr_spacing", 64'(cyc - last_cyc), 64'd4);
                last_cyc = cyc;
                if (req_ready[2]) req_valid[2] = 1'b0;
                n++;
                if (n == 7) req_valid[2] = 1'b1;
                if (n == 10) req_valid = '0;
            end
        end
        mem_rsp_valid = 1'b0;
        mem_cmd_ready = 1'b0;
        check("rr_grant_count", 64'(n), 64'd10);

        // Reset while waiting on the controller: silent abandon, pointer back to 0.
        run_vec(mk(1, 1'b0, 24'h000777, 32'h0, 0, 1, 32'h11112222, 32'h11112222, 1'b0, 1, 2));
        req_valid[1] = 1'b1;
        @(negedge clk);
        check("mid_req_ready", 64'(req_ready), 64'(4'b0010));
        req_valid[1] = 1'b0;
        mem_cmd_ready = 1'b1;
        @(negedge clk);
        mem_cmd_ready = 1'b0;
        @(negedge clk);
        check("mid_busy_wait", 64'(busy), 64'd1);
        reset_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("post_reset_no_rsp", 64'(rsp_valid), 64'd0);
            check("post_reset_busy", 64'(busy), 64'd0);
        end
        req_valid = 4'b0101;
        @(negedge clk);
        check("post_reset_grant", 64'(req_ready), 64'(4'b0001));
        check("post_reset_gid", 64'(grant_id), 64'd0);
        req_valid = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
